// File: rtl/ddr3_tg_pkg.sv
// Shared types and helpers for the DDR3 write/read-back traffic generator.
`default_nettype none

package ddr3_tg_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_CMD  = 3'd1,
      WR_DATA = 3'd2,
      RD_CMD  = 3'd3,
      RD_DATA = 3'd4,
      NEXT    = 3'd5,
      DONE    = 3'd6
   } tg_state_t;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   // One 32-bit lane of the pattern; callers replicate it across the data width.
   function automatic logic [31:0] pat_word32(input logic [31:0] base, input logic [7:0] beat);
      return base + {24'd0, beat};
   endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_tg_checker.sv
// Read-back checker: builds the expected word for the current read beat and
// keeps a saturating count of mismatching words.
`default_nettype none

module ddr3_tg_checker
   import ddr3_tg_pkg::*;
#(
   parameter int DATA_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              valid,
   input  logic [31:0]       pat_base,
   input  logic [7:0]        rd_beat,
   input  logic [DATA_W-1:0] rd_data,
   output logic [15:0]       err_cnt
);

   logic [DATA_W-1:0] expected;

   assign expected = {(DATA_W/32){pat_word32(pat_base, rd_beat)}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 16'd0;
      end else if (clear) begin
         err_cnt <= 16'd0;
      end else if (valid && (rd_data != expected) && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ddr3_traffic_gen.sv
// DDR3 write/read-back traffic generator on the DMA_APP_TOP ex_wr_*/ex_rd_* interface.
// Optional build macro TG_ERR_INJECT_EN corrupts one write word of burst 0.
`default_nettype none

module ddr3_traffic_gen
   import ddr3_tg_pkg::*;
#(
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 256,
   parameter int BURST_LEN  = 64,
   parameter int ADDR_STEP  = 512,
   parameter int NUM_BURSTS = 16,
   parameter int BASE_ADDR  = 0,
   parameter int ERR_BEAT   = 5
) (
   input  logic                I_Clk,
   input  logic                I_Rst_n,
   input  logic                I_Start,
   input  logic                init_calib_complete,
   output logic                ex_wr_start,
   output logic [ADDR_W-1:0]   ex_wr_addr,
   output logic [2:0]          ex_wr_cmd,
   output logic [7:0]          ex_wr_burst_len,
   output logic [DATA_W-1:0]   ex_wr_data,
   output logic [DATA_W/8-1:0] ex_wr_wdf_mask,
   input  logic                ex_wr_burst_start,
   input  logic                ex_wr_burst_end,
   input  logic                ex_wr_rd_en,
   output logic                ex_rd_start,
   output logic [ADDR_W-1:0]   ex_rd_addr,
   output logic [2:0]          ex_rd_cmd,
   output logic [7:0]          ex_rd_burst_len,
   input  logic [DATA_W-1:0]   ex_rd_data,
   input  logic                ex_rd_wr_en,
   output logic                O_Busy,
   output logic                O_Done,
   output logic                O_Pass,
   output logic [15:0]         O_Err_Cnt
);

   localparam logic [7:0]        LEN8       = 8'(BURST_LEN);
   localparam logic [7:0]        LAST_BEAT  = 8'(BURST_LEN - 1);
   localparam logic [31:0]       LAST_BURST = 32'(NUM_BURSTS - 1);
   localparam logic [31:0]       PAT_STEP   = 32'(BURST_LEN);
   localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(ADDR_STEP);

   tg_state_t   state, next_state;
   logic [31:0] burst_idx;
   logic [31:0] pat_base;
   logic [7:0]  wr_beat;
   logic [7:0]  rd_beat;
   logic [7:0]  wr_beat_eff;
   logic        accept;
   logic        wr_pop;
   logic        rd_valid;
   logic        last_burst;
   logic [DATA_W-1:0] clean_word;
   logic        unused_burst_start;

   // Burst acceptance is not needed: the consumer paces the data via ex_wr_rd_en.
   assign unused_burst_start = ex_wr_burst_start;

   assign accept     = (state == IDLE) && I_Start && init_calib_complete;
   assign wr_pop     = (state == WR_DATA) && ex_wr_rd_en && (wr_beat != LEN8);
   assign rd_valid   = (state == RD_DATA) && ex_rd_wr_en;
   assign last_burst = (burst_idx == LAST_BURST);

   assign ex_wr_start    = (state == WR_CMD);
   assign ex_rd_start    = (state == RD_CMD);
   assign ex_wr_cmd      = CMD_WR;
   assign ex_rd_cmd      = CMD_RD;
   assign ex_wr_wdf_mask = '0;

   // Pops beyond the burst length leave the counter at BURST_LEN; the data holds the last word.
   assign wr_beat_eff = (wr_beat == LEN8) ? LAST_BEAT : wr_beat;
   assign clean_word  = {(DATA_W/32){pat_word32(pat_base, wr_beat_eff)}};

`ifdef TG_ERR_INJECT_EN
   logic inject;
   assign inject     = (burst_idx == 32'd0) && (wr_beat_eff == 8'(ERR_BEAT));
   assign ex_wr_data = clean_word ^ {{(DATA_W-1){1'b0}}, inject};
`else
   assign ex_wr_data = clean_word;
   if (ERR_BEAT >= BURST_LEN) begin : g_err_beat_unused
   end
`endif

   always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = WR_CMD;
         WR_CMD:  next_state = WR_DATA;
         WR_DATA: if (ex_wr_burst_end) next_state = RD_CMD;
         RD_CMD:  next_state = RD_DATA;
         RD_DATA: if (rd_valid && (rd_beat == LAST_BEAT)) next_state = NEXT;
         NEXT:    next_state = last_burst ? DONE : WR_CMD;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
         burst_idx       <= 32'd0;
         pat_base        <= 32'd0;
         wr_beat         <= 8'd0;
         rd_beat         <= 8'd0;
         ex_wr_addr      <= '0;
         ex_wr_burst_len <= 8'd0;
         ex_rd_addr      <= '0;
         ex_rd_burst_len <= 8'd0;
         O_Busy          <= 1'b0;
         O_Done          <= 1'b0;
         O_Pass          <= 1'b0;
      end else begin
         if (accept) begin
            burst_idx       <= 32'd0;
            pat_base        <= 32'd0;
            wr_beat         <= 8'd0;
            rd_beat         <= 8'd0;
            ex_wr_addr      <= BASE_A;
            ex_wr_burst_len <= LEN8;
            O_Busy          <= 1'b1;
            O_Done          <= 1'b0;
            O_Pass          <= 1'b0;
         end
         if (wr_pop) begin
            wr_beat <= wr_beat + 8'd1;
         end
         if (rd_valid) begin
            rd_beat <= rd_beat + 8'd1;
         end
         if ((state == WR_DATA) && ex_wr_burst_end) begin
            ex_rd_addr      <= ex_wr_addr;
            ex_rd_burst_len <= LEN8;
         end
         if (state == NEXT) begin
            if (last_burst) begin
               O_Busy <= 1'b0;
               O_Done <= 1'b1;
               O_Pass <= (O_Err_Cnt == 16'd0);
            end else begin
               burst_idx  <= burst_idx + 32'd1;
               pat_base   <= pat_base + PAT_STEP;
               wr_beat    <= 8'd0;
               rd_beat    <= 8'd0;
               ex_wr_addr <= ex_wr_addr + STEP_A;
            end
         end
      end
   end

   ddr3_tg_checker #(
      .DATA_W(DATA_W)
   ) u_checker (
      .clk      (I_Clk),
      .rst_n    (I_Rst_n),
      .clear    (accept),
      .valid    (rd_valid),
      .pat_base (pat_base),
      .rd_beat  (rd_beat),
      .rd_data  (ex_rd_data),
      .err_cnt  (O_Err_Cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_ddr3_traffic_gen.sv
// Self-checking bench for ddr3_traffic_gen with an ideal DMA/DDR3 responder.
`timescale 1ns/1ps
`default_nettype none

module tb_ddr3_traffic_gen;

   localparam int ADDR_W   = 28;
   localparam int DATA_W   = 256;
   localparam int BL       = 64;
   localparam int STEP     = 512;
   localparam int NB       = 2;
   localparam int BASE     = 0;
   localparam int ERR_BEAT = 5;
`ifdef TG_ERR_INJECT_EN
   localparam int INJ = 1;
`else
   localparam int INJ = 0;
`endif

   logic                clk = 1'b0;
   logic                I_Rst_n;
   logic                I_Start;
   logic                init_calib_complete;
   logic                ex_wr_start;
   logic [ADDR_W-1:0]   ex_wr_addr;
   logic [2:0]          ex_wr_cmd;
   logic [7:0]          ex_wr_burst_len;
   logic [DATA_W-1:0]   ex_wr_data;
   logic [DATA_W/8-1:0] ex_wr_wdf_mask;
   logic                ex_wr_burst_start;
   logic                ex_wr_burst_end;
   logic                ex_wr_rd_en;
   logic                ex_rd_start;
   logic [ADDR_W-1:0]   ex_rd_addr;
   logic [2:0]          ex_rd_cmd;
   logic [7:0]          ex_rd_burst_len;
   logic [DATA_W-1:0]   ex_rd_data;
   logic                ex_rd_wr_en;
   logic                O_Busy;
   logic                O_Done;
   logic                O_Pass;
   logic [15:0]         O_Err_Cnt;

   always #5 clk = ~clk;

   ddr3_traffic_gen #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .ADDR_STEP(STEP),
      .NUM_BURSTS(NB), .BASE_ADDR(BASE), .ERR_BEAT(ERR_BEAT)
   ) dut (
      .I_Clk(clk), .I_Rst_n(I_Rst_n), .I_Start(I_Start),
      .init_calib_complete(init_calib_complete),
      .ex_wr_start(ex_wr_start), .ex_wr_addr(ex_wr_addr), .ex_wr_cmd(ex_wr_cmd),
      .ex_wr_burst_len(ex_wr_burst_len), .ex_wr_data(ex_wr_data),
      .ex_wr_wdf_mask(ex_wr_wdf_mask), .ex_wr_burst_start(ex_wr_burst_start),
      .ex_wr_burst_end(ex_wr_burst_end), .ex_wr_rd_en(ex_wr_rd_en),
      .ex_rd_start(ex_rd_start), .ex_rd_addr(ex_rd_addr), .ex_rd_cmd(ex_rd_cmd),
      .ex_rd_burst_len(ex_rd_burst_len), .ex_rd_data(ex_rd_data),
      .ex_rd_wr_en(ex_rd_wr_en), .O_Busy(O_Busy), .O_Done(O_Done),
      .O_Pass(O_Pass), .O_Err_Cnt(O_Err_Cnt)
   );

   typedef struct {
      bit toggle;
      bit corrupt;
      bit start_mid;
      bit calib_drop;
      int exp_err;
      bit exp_pass;
   } vec_t;

   vec_t              vecs[4];
   int                checks = 0;
   int                fails  = 0;
   logic [DATA_W-1:0] wmem [NB][BL];

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] exp_word(input int b, input int beat);
      logic [31:0]       p;
      logic [DATA_W-1:0] w;
      p = 32'(b * BL + beat);
      w = {(DATA_W/32){p}};
      if (INJ == 1 && b == 0 && beat == ERR_BEAT) w[0] = ~w[0];
      return w;
   endfunction

   task automatic run_scenario(input vec_t v, input string tag);
      int                n, beat, cyc, bad, extra;
      logic [DATA_W-1:0] d;
      @(negedge clk); I_Start = 1'b1;
      @(negedge clk); I_Start = 1'b0;
      for (int b = 0; b < NB; b++) begin
         n = 0;
         while (ex_wr_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
         chk($sformatf("%s wr_start b%0d", tag, b), ex_wr_start, 1);
         if (ex_wr_start !== 1'b1) return;
         chk($sformatf("%s wr_addr b%0d", tag, b), ex_wr_addr, BASE + b * STEP);
         chk($sformatf("%s wr_len b%0d", tag, b), ex_wr_burst_len, BL);
         chk($sformatf("%s busy b%0d", tag, b), O_Busy, 1);
         chk($sformatf("%s fwft word0 b%0d", tag, b), ex_wr_data, exp_word(b, 0));
         @(negedge clk);
         if (b == 0 && v.start_mid) I_Start = 1'b1;
         if (b == 0 && v.calib_drop) init_calib_complete = 1'b0;
         beat = 0; cyc = 0; bad = 0;
         while (beat < BL && cyc < 4 * BL) begin
            if (!v.toggle || (cyc % 2) == 0) begin
               wmem[b][beat] = ex_wr_data;
               if (ex_wr_data !== exp_word(b, beat)) bad++;
               beat++;
               ex_wr_rd_en = 1'b1;
            end else begin
               ex_wr_rd_en = 1'b0;
            end
            ex_wr_burst_start = (cyc == 0);
            cyc++;
            @(negedge clk);
            I_Start = 1'b0;
         end
         ex_wr_burst_start = 1'b0;
         chk($sformatf("%s wr pattern errors b%0d", tag, b), bad, 0);
         chk($sformatf("%s wr hold b%0d", tag, b), ex_wr_data, exp_word(b, BL - 1));
         // Over-pop plus a stray read strobe outside RD_DATA; both must be ignored.
         ex_wr_rd_en = 1'b1; ex_rd_wr_en = 1'b1; ex_rd_data = '1;
         @(negedge clk);
         chk($sformatf("%s wr hold after extra pop b%0d", tag, b), ex_wr_data, exp_word(b, BL - 1));
         ex_wr_rd_en = 1'b0; ex_rd_wr_en = 1'b0; ex_wr_burst_end = 1'b1;
         @(negedge clk);
         ex_wr_burst_end = 1'b0;
         n = 0;
         while (ex_rd_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
         chk($sformatf("%s rd_start b%0d", tag, b), ex_rd_start, 1);
         if (ex_rd_start !== 1'b1) return;
         chk($sformatf("%s rd_addr b%0d", tag, b), ex_rd_addr, BASE + b * STEP);
         chk($sformatf("%s rd_len b%0d", tag, b), ex_rd_burst_len, BL);
         @(negedge clk);
         for (int k = 0; k < BL; k++) begin
            d = wmem[b][k];
            if (v.corrupt && b == 0 && (k == 3 || k == 40)) d[7] = ~d[7];
            ex_rd_data = d; ex_rd_wr_en = 1'b1;
            @(negedge clk);
         end
         ex_rd_wr_en = 1'b0;
      end
      chk($sformatf("%s burst1 word63", tag), wmem[1][63], {8{32'd127}});
      n = 0;
      while (O_Done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("%s done", tag), O_Done, 1);
      chk($sformatf("%s busy at done", tag), O_Busy, 0);
      chk($sformatf("%s err_cnt", tag), O_Err_Cnt, v.exp_err);
      chk($sformatf("%s pass", tag), O_Pass, v.exp_pass);
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ex_wr_start === 1'b1) extra++;
      end
      chk($sformatf("%s no extra wr_start", tag), extra, 0);
      chk($sformatf("%s done sticky", tag), O_Done, 1);
      init_calib_complete = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt, busy_seen;
      vecs[0] = '{0, 0, 0, 0, INJ,     (INJ == 0)};
      vecs[1] = '{1, 0, 0, 0, INJ,     (INJ == 0)};
      vecs[2] = '{0, 1, 0, 0, 2 + INJ, 1'b0};
      vecs[3] = '{0, 0, 1, 1, INJ,     (INJ == 0)};

      I_Rst_n = 1'b0; I_Start = 1'b0; init_calib_complete = 1'b0;
      ex_wr_burst_start = 1'b0; ex_wr_burst_end = 1'b0; ex_wr_rd_en = 1'b0;
      ex_rd_data = '0; ex_rd_wr_en = 1'b0;
      repeat (3) @(negedge clk);
      I_Rst_n = 1'b1;
      @(negedge clk);
      chk("reset busy", O_Busy, 0);
      chk("reset done", O_Done, 0);
      chk("reset pass", O_Pass, 0);
      chk("reset err_cnt", O_Err_Cnt, 0);
      chk("reset wr_start", ex_wr_start, 0);
      chk("reset rd_start", ex_rd_start, 0);
      chk("reset wr_data", ex_wr_data, 0);
      chk("wr_cmd const", ex_wr_cmd, 3'b000);
      chk("rd_cmd const", ex_rd_cmd, 3'b001);
      chk("wdf_mask const", ex_wr_wdf_mask, 0);

      // Start with calibration low is dropped.
      I_Start = 1'b1; @(negedge clk); I_Start = 1'b0;
      cnt = 0; busy_seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (ex_wr_start === 1'b1) cnt++;
         if (O_Busy === 1'b1) busy_seen++;
         @(negedge clk);
      end
      chk("nocal wr_start count", cnt, 0);
      chk("nocal busy cycles", busy_seen, 0);

      init_calib_complete = 1'b1;
      for (int i = 0; i < 4; i++) run_scenario(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of a write burst.
      @(negedge clk); I_Start = 1'b1; @(negedge clk); I_Start = 1'b0;
      n = 0;
      while (ex_wr_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("rst-mid wr_start", ex_wr_start, 1);
      @(negedge clk);
      ex_wr_rd_en = 1'b1;
      repeat (10) @(negedge clk);
      ex_wr_rd_en = 1'b0;
      I_Rst_n = 1'b0;
      #1;
      chk("rst-mid busy", O_Busy, 0);
      chk("rst-mid wr_len", ex_wr_burst_len, 0);
      chk("rst-mid wr_data", ex_wr_data, 0);
      chk("rst-mid rd_addr", ex_rd_addr, 0);
      chk("rst-mid rd_len", ex_rd_burst_len, 0);
      chk("rst-mid wr_start", ex_wr_start, 0);
      @(negedge clk); @(negedge clk);
      I_Rst_n = 1'b1;
      run_scenario(vecs[0], "after-reset");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
